// File: rtl/motor_pkg.sv
// motor_pkg: shared definitions for the stepper motion blocks.
// Holds the common data width, the ramp FSM state encoding and small
// unsigned saturating/min/max helpers also used by the position tracker.
package motor_pkg;

  // Width of periods, step counts and internal counters.
  localparam int W = 32;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } state_e;

  // a + b, clamped to all-ones instead of wrapping.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[W] ? '1 : sum[W-1:0];
  endfunction

  // a - b, clamped to zero instead of wrapping.
  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic [W-1:0] min_u(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [W-1:0] max_u(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_interval_timer.sv
// step_interval_timer: counts clocks of the current step interval.
// Ports: clk/rst_n (sync, active-low), run enables counting, period is the
// interval length (>= 1 while running), expire is a combinational pulse in the
// cycle where the timer holds period-1, i.e. the last cycle of the interval.
module step_interval_timer
  import motor_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic [W-1:0] period,
  output logic         expire
);

  logic [W-1:0] timer_q;
  logic [W-1:0] timer_d;

  always_comb begin
    expire  = run && (timer_q == (period - ONE));
    timer_d = timer_q + ONE;
    // Held at zero while idle so the first interval after a start is full length.
    if (!run || expire) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/motor_step_rate.sv
// motor_step_rate: trapezoidal step-rate generator feeding the phase sequencer.
// Ports: clk, PRESERN (sync active-low reset), start/abort pulses, move command
// (move_steps, start_period, min_period, accel_step) sampled with start;
// outputs step_tick (one-cycle enable), cur_period, busy, done (all registered).
module motor_step_rate
  import motor_pkg::*;
(
  input  logic         clk,
  input  logic         PRESERN,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] move_steps,
  input  logic [W-1:0] start_period,
  input  logic [W-1:0] min_period,
  input  logic [W-1:0] accel_step,
  output logic         step_tick,
  output logic [W-1:0] cur_period,
  output logic         busy,
  output logic         done
);

  state_e       state_q, state_d;
  logic [W-1:0] steps_left_q, steps_left_d;
  logic [W-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] p_start_q, p_start_d;
  logic [W-1:0] p_min_q, p_min_d;
  logic [W-1:0] p_acc_q, p_acc_d;
  logic         step_tick_q, step_tick_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  logic         running;
  logic         expire;
  logic         last_tick;
  logic [W-1:0] start_p;
  logic [W-1:0] min_p;
  logic [W-1:0] steps_eff;
  logic [W-1:0] steps_post;
  logic [W-1:0] acc_period;
  logic [W-1:0] dec_period;

  assign running = (state_q != ST_IDLE);

  step_interval_timer u_timer (
    .clk    (clk),
    .rst_n  (PRESERN),
    .run    (running),
    .period (period_q),
    .expire (expire)
  );

  // Command sanitising and per-tick arithmetic, kept apart from the FSM.
  always_comb begin
    start_p = (start_period == '0) ? ONE : start_period;
    min_p   = (min_period == '0) ? ONE : min_period;
    min_p   = min_u(min_p, start_p);

    // An abort trims the remaining steps to what the ramp-down needs; the
    // interval already being timed is left untouched.
    steps_eff = abort ? min_u(steps_left_q, sat_add(ramp_cnt_q, ONE)) : steps_left_q;
    // steps_left never sits at zero while running, so this cannot wrap.
    steps_post = steps_eff - ONE;

    acc_period = max_u(sat_sub(period_q, p_acc_q), p_min_q);
    dec_period = min_u(sat_add(period_q, p_acc_q), p_start_q);
  end

  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    ramp_cnt_d   = ramp_cnt_q;
    period_d     = period_q;
    p_start_d    = p_start_q;
    p_min_d      = p_min_q;
    p_acc_d      = p_acc_q;
    step_tick_d  = 1'b0;
    done_d       = 1'b0;
    last_tick    = 1'b0;

    if (state_q == ST_IDLE) begin
      period_d = '0;
      if (start) begin
        if (move_steps == '0) begin
          // Empty move: acknowledge without ever going busy.
          done_d = 1'b1;
        end else begin
          p_start_d    = start_p;
          p_min_d      = min_p;
          p_acc_d      = accel_step;
          period_d     = start_p;
          ramp_cnt_d   = '0;
          steps_left_d = move_steps;
          state_d      = ((start_p > min_p) && (accel_step != '0)) ? ST_ACCEL : ST_CRUISE;
        end
      end
    end else begin
      steps_left_d = steps_eff;
      if (expire) begin
        step_tick_d  = 1'b1;
        steps_left_d = steps_post;
        if (steps_post == '0) begin
          last_tick  = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
          period_d   = '0;
          ramp_cnt_d = '0;
        end else if ((state_q == ST_DECEL) || (steps_post <= ramp_cnt_q)) begin
          // Remaining steps only cover the ramp back down: unwind it.
          period_d   = dec_period;
          ramp_cnt_d = (ramp_cnt_q == '0) ? '0 : (ramp_cnt_q - ONE);
          state_d    = ST_DECEL;
        end else if ((state_q == ST_ACCEL) && (steps_post > ramp_cnt_q) &&
                     ((steps_post - ramp_cnt_q) > ONE)) begin
          // Room for one more accel step plus its matching decel step.
          period_d   = acc_period;
          ramp_cnt_d = ramp_cnt_q + ONE;
          state_d    = (acc_period == p_min_q) ? ST_CRUISE : ST_ACCEL;
        end else begin
          state_d = ST_CRUISE;
        end
      end
    end

    // busy covers the cycle of the final tick so it drops right after done.
    busy_d = (state_d != ST_IDLE) || last_tick;
  end

  always_ff @(posedge clk) begin
    if (!PRESERN) begin
      state_q      <= ST_IDLE;
      steps_left_q <= '0;
      ramp_cnt_q   <= '0;
      period_q     <= '0;
      p_start_q    <= '0;
      p_min_q      <= '0;
      p_acc_q      <= '0;
      step_tick_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      ramp_cnt_q   <= ramp_cnt_d;
      period_q     <= period_d;
      p_start_q    <= p_start_d;
      p_min_q      <= p_min_d;
      p_acc_q      <= p_acc_d;
      step_tick_q  <= step_tick_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign step_tick  = step_tick_q;
  assign cur_period = period_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_motor_step_rate.sv
`timescale 1ns/1ps
module tb_motor_step_rate;

  typedef struct {
    longint cyc;
    longint per;
    bit     tick;
    bit     last;
  } exp_t;

  logic        clk = 1'b0;
  logic        PRESERN = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] move_steps = '0;
  logic [31:0] start_period = '0;
  logic [31:0] min_period = '0;
  logic [31:0] accel_step = '0;
  logic        step_tick;
  logic [31:0] cur_period;
  logic        busy;
  logic        done;

  exp_t        sb[$];
  longint      cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] prev_per = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  motor_step_rate dut (
    .clk          (clk),
    .PRESERN      (PRESERN),
    .start        (start),
    .abort        (abort),
    .move_steps   (move_steps),
    .start_period (start_period),
    .min_period   (min_period),
    .accel_step   (accel_step),
    .step_tick    (step_tick),
    .cur_period   (cur_period),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Monitor: every tick or done the DUT shows is matched against the queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (PRESERN && (step_tick || done)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {62'd0, step_tick, done}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("step_tick", step_tick, e.tick);
        chk("done", done, e.last);
        chk("busy_at_event", busy, e.tick);
        if (e.tick) chk("interval_period", prev_per, e.per);
      end
    end
    prev_per = cur_period;
  end

  // Reference model, tick by tick: walks the move profile and records when
  // each tick lands (cycles after the start edge) and how long its interval is.
  task automatic model(input longint e0, input longint steps, input longint sp,
                       input longint mp, input longint acc, input longint abort_at);
    longint ps, pm, s, r, p, t, tprev;
    int     phase;  // 0 speeding up, 1 cruising, 2 slowing down
    exp_t   x;
    ps = (sp == 0) ? 1 : sp;
    pm = (mp == 0) ? 1 : mp;
    if (pm > ps) pm = ps;
    if (steps == 0) begin
      x.cyc = e0; x.per = 0; x.tick = 1'b0; x.last = 1'b1;
      sb.push_back(x);
      return;
    end
    phase = (ps > pm && acc > 0) ? 0 : 1;
    s = steps; r = 0; p = ps; t = 0;
    while (s > 0) begin
      tprev = t;
      t = t + p;
      if (abort_at > tprev && abort_at <= t && s > r + 1) s = r + 1;
      s = s - 1;
      x.cyc = e0 + t; x.per = p; x.tick = 1'b1; x.last = (s == 0);
      sb.push_back(x);
      if (s == 0) break;
      if (phase == 2 || s <= r) begin
        p = (p + acc > ps) ? ps : p + acc;
        if (r > 0) r = r - 1;
        phase = 2;
      end else if (phase == 0 && s > r + 1) begin
        p = (p > acc) ? p - acc : 0;
        if (p < pm) p = pm;
        r = r + 1;
        if (p == pm) phase = 1;
      end else begin
        phase = 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Issue one move; abort_at / busy_start_at are edge offsets from the start
  // edge (0 = never).
  task automatic run_move(input logic [31:0] steps, input logic [31:0] sp,
                          input logic [31:0] mp, input logic [31:0] acc,
                          input int abort_at, input int busy_start_at);
    longint e0;
    e0 = cyc + 1;
    model(e0, steps, sp, mp, acc, abort_at);
    move_steps = steps; start_period = sp; min_period = mp; accel_step = acc;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, (steps != 0));
    for (int i = 0; i < 4000 && sb.size() != 0; i++) begin
      abort = (abort_at > 0) && (cyc + 1 == e0 + abort_at);
      start = (busy_start_at > 0) && (cyc + 1 == e0 + busy_start_at);
      if (start) begin
        move_steps = 2; start_period = 3; min_period = 1; accel_step = 1;
      end
      step();
    end
    abort = 1'b0;
    start = 1'b0;
    if (sb.size() != 0) begin
      chk("move_timeout", sb.size(), 0);
      sb.delete();
    end
    step();
    step();
    chk("idle_busy", busy, 1'b0);
    chk("idle_cur_period", cur_period, 32'd0);
  endtask

  initial begin
    longint e0;
    logic [31:0] rs, rsp, rmp, racc;
    int          rab;

    PRESERN = 1'b0;
    repeat (3) step();
    chk("reset_tick", step_tick, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_cur_period", cur_period, 32'd0);
    PRESERN = 1'b1;
    step();

    run_move(3, 5, 5, 0, 0, 0);      // constant speed
    run_move(10, 10, 4, 2, 0, 0);    // full trapezoid
    run_move(4, 10, 4, 2, 0, 0);     // short move, 10,8,8,10
    run_move(3, 10, 4, 2, 0, 0);     // short move, 10,8,10
    run_move(10, 10, 4, 2, 30, 0);   // abort during the fifth interval
    run_move(0, 10, 4, 2, 0, 0);     // empty move
    run_move(5, 10, 20, 2, 0, 0);    // min above start: constant 10
    run_move(10, 10, 4, 2, 0, 5);    // start while busy is ignored
    run_move(4, 1, 1, 0, 0, 0);      // back-to-back ticks
    run_move(6, 0, 0, 3, 0, 0);      // zero periods treated as 1
    run_move(6, 9, 2, 32'hFFFF_FFF0, 0, 0);  // saturating ramp

    // Reset in the middle of cruise.
    e0 = cyc + 1;
    model(e0, 10, 10, 4, 2, 0);
    move_steps = 10; start_period = 10; min_period = 4; accel_step = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < e0 + 25) step();
    PRESERN = 1'b0;
    step();
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_cur_period", cur_period, 32'd0);
    chk("midreset_done", done, 1'b0);
    chk("midreset_tick", step_tick, 1'b0);
    chk("ticks_before_reset", sb.size(), 7);
    sb.delete();
    PRESERN = 1'b1;
    repeat (40) step();
    run_move(10, 10, 4, 2, 0, 0);

    // Randomised moves.
    for (int n = 0; n < 40; n++) begin
      rs   = $urandom_range(0, 16);
      rsp  = $urandom_range(0, 12);
      rmp  = $urandom_range(0, 14);
      racc = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 : $urandom_range(0, 4);
      rab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 150)) : 0;
      run_move(rs, rsp, rmp, racc, rab, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
